// File: rtl/mdio_arbiter.sv
// Two-requester round-robin arbiter in front of an MDIO frame transmitter.
// Builds the 32-bit management frame for the winner, launches it, and waits
// for either a fixed write frame time or read data / read timeout.
module mdio_arbiter #(
  parameter int unsigned FRAME_CYC = 64,
  parameter int unsigned TIMEOUT   = 200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic        rd0,
  input  logic        rd1,
  input  logic [4:0]  phy0,
  input  logic [4:0]  phy1,
  input  logic [4:0]  reg0,
  input  logic [4:0]  reg1,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  output logic        done0,
  output logic        done1,
  output logic        err,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        MDIO_start,
  output logic [31:0] T_data,
  input  logic        data_RDY,
  input  logic [15:0] RD_data
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t             state;
  logic               last_grant;
  logic               grant;
  logic               is_rd;
  logic [CNT_W-1:0]   cnt;

  logic               win_c;
  logic               sel_rd_c;
  logic [4:0]         sel_phy_c;
  logic [4:0]         sel_reg_c;
  logic [15:0]        sel_wdata_c;
  logic [31:0]        frame_c;

  // Round-robin winner: a lone request wins, a tie goes to the requester not served last.
  always_comb begin
    win_c = 1'b0;
    if (req0 && req1) begin
      win_c = ~last_grant;
    end else if (req1) begin
      win_c = 1'b1;
    end
  end

  // Frame for the current winner: ST, OP, PHY, REG, TA, DATA.
  always_comb begin
    sel_rd_c    = win_c ? rd1    : rd0;
    sel_phy_c   = win_c ? phy1   : phy0;
    sel_reg_c   = win_c ? reg1   : reg0;
    sel_wdata_c = win_c ? wdata1 : wdata0;
    if (sel_rd_c) begin
      frame_c = {2'b01, 2'b10, sel_phy_c, sel_reg_c, 2'b00, 16'h0000};
    end else begin
      frame_c = {2'b01, 2'b01, sel_phy_c, sel_reg_c, 2'b10, sel_wdata_c};
    end
  end

  // Transaction FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      grant      <= 1'b0;
      is_rd      <= 1'b0;
      cnt        <= '0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      err        <= 1'b0;
      rdata      <= 16'h0000;
      busy       <= 1'b0;
      MDIO_start <= 1'b0;
      T_data     <= 32'h0000_0000;
    end else begin
      done0      <= 1'b0;
      done1      <= 1'b0;
      MDIO_start <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            grant  <= win_c;
            is_rd  <= sel_rd_c;
            T_data <= frame_c;
            busy   <= 1'b1;
            state  <= START;
          end
        end
        START: begin
          MDIO_start <= 1'b1;
          cnt        <= '0;
          state      <= WAIT;
        end
        WAIT: begin
          if (is_rd) begin
            if (data_RDY) begin
              rdata <= RD_data;
              err   <= 1'b0;
              state <= DONE;
            end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
              rdata <= 16'h0000;
              err   <= 1'b1;
              state <= DONE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else begin
            if (cnt == CNT_W'(FRAME_CYC - 1)) begin
              err   <= 1'b0;
              state <= DONE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        DONE: begin
          done0      <= ~grant;
          done1      <= grant;
          last_grant <= grant;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_arbiter.sv
// Directed self-checking bench for mdio_arbiter (default parameters).
module tb_mdio_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1, rd0, rd1;
  logic [4:0]  phy0, phy1, reg0, reg1;
  logic [15:0] wdata0, wdata1;
  logic        done0, done1, err, busy, MDIO_start;
  logic [15:0] rdata;
  logic [31:0] T_data;
  logic        data_RDY;
  logic [15:0] RD_data;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;
  logic seen;

  mdio_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .req0       (req0),
    .req1       (req1),
    .rd0        (rd0),
    .rd1        (rd1),
    .phy0       (phy0),
    .phy1       (phy1),
    .reg0       (reg0),
    .reg1       (reg1),
    .wdata0     (wdata0),
    .wdata1     (wdata1),
    .done0      (done0),
    .done1      (done1),
    .err        (err),
    .rdata      (rdata),
    .busy       (busy),
    .MDIO_start (MDIO_start),
    .T_data     (T_data),
    .data_RDY   (data_RDY),
    .RD_data    (RD_data)
  );

  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_done0"},  32'(done0), 0);
    check({tag, "_done1"},  32'(done1), 0);
    check({tag, "_err"},    32'(err), 0);
    check({tag, "_rdata"},  32'(rdata), 0);
    check({tag, "_busy"},   32'(busy), 0);
    check({tag, "_start"},  32'(MDIO_start), 0);
    check({tag, "_tdata"},  T_data, 0);
  endtask

  // Wait for the given requester's done; optionally pulse data_RDY before tick rdy_at.
  task automatic wait_done(input int who, input int limit, input int rdy_at,
                           input logic [15:0] rdy_val, output int cycles);
    logic found;
    logic mine, other;
    found  = 1'b0;
    cycles = 0;
    while (!found && cycles < limit) begin
      data_RDY = (cycles == rdy_at);
      RD_data  = rdy_val;
      tick();
      data_RDY = 1'b0;
      cycles++;
      mine  = (who == 0) ? done0 : done1;
      other = (who == 0) ? done1 : done0;
      if (other)      check("no_other_done", 32'(other), 0);
      if (MDIO_start) check("no_extra_start", 32'(MDIO_start), 0);
      if (mine) found = 1'b1;
    end
    if (!found) check("done_seen", 32'(found), 1);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    req0 = 0; req1 = 0; rd0 = 0; rd1 = 0;
    phy0 = 0; phy1 = 0; reg0 = 0; reg1 = 0;
    wdata0 = 0; wdata1 = 0; data_RDY = 0; RD_data = 0;
    tick(); tick(); tick();
    check_zero_outputs("reset");
    reset = 1'b0;
    tick();

    // Write from requester 0, with a stray data_RDY that must be ignored.
    req0 = 1; rd0 = 0; phy0 = 5'h1F; reg0 = 5'h12; wdata0 = 16'h28DB;
    tick();
    check("w_start_early", 32'(MDIO_start), 0);
    check("w_busy", 32'(busy), 1);
    tick();
    check("w_start", 32'(MDIO_start), 1);
    check("w_tdata", T_data, 32'h5FCA28DB);
    wait_done(0, 300, 10, 16'hFFFF, cyc);
    check("w_latency", 32'(cyc), 65);
    check("w_err", 32'(err), 0);
    check("w_rdata_ignored", 32'(rdata), 0);
    check("w_tdata_stable", T_data, 32'h5FCA28DB);
    req0 = 0;
    tick();
    check("w_done_pulse", 32'(done0), 0);
    check("w_idle_busy", 32'(busy), 0);

    // Read from requester 1; write data must not leak into the frame.
    req1 = 1; rd1 = 1; phy1 = 5'h1F; reg1 = 5'h12; wdata1 = 16'hBEEF;
    tick();
    tick();
    check("r_start", 32'(MDIO_start), 1);
    check("r_tdata", T_data, 32'h6FC80000);
    wait_done(1, 300, 5, 16'h0E8C, cyc);
    check("r_latency", 32'(cyc), 7);
    check("r_rdata", 32'(rdata), 32'h0E8C);
    check("r_err", 32'(err), 0);
    req1 = 0;
    tick();

    // Read timeout from requester 0.
    req0 = 1; rd0 = 1; phy0 = 5'h01; reg0 = 5'h02;
    tick();
    tick();
    check("to_tdata", T_data, 32'h60880000);
    wait_done(0, 400, -1, 16'h0000, cyc);
    check("to_latency", 32'(cyc), 201);
    check("to_err", 32'(err), 1);
    check("to_rdata", 32'(rdata), 0);
    req0 = 0;
    tick();

    // Tie right after requester 0 was served: requester 1 must win.
    req0 = 1; rd0 = 0; phy0 = 5'h00; reg0 = 5'h00; wdata0 = 16'h1111;
    req1 = 1; rd1 = 0; phy1 = 5'h02; reg1 = 5'h03; wdata1 = 16'h2222;
    tick();
    tick();
    check("tie1_tdata", T_data, 32'h510E2222);
    wait_done(1, 300, -1, 16'h0000, cyc);
    check("tie1_latency", 32'(cyc), 65);
    check("tie1_err", 32'(err), 0);
    req1 = 0;
    tick();
    tick();
    check("tie1_next_start", 32'(MDIO_start), 1);
    check("tie1_next_tdata", T_data, 32'h50021111);
    wait_done(0, 300, -1, 16'h0000, cyc);
    check("tie1_next_latency", 32'(cyc), 65);
    req0 = 0;
    tick();

    // Reset restores the pointer: tie after reset goes to requester 0, then 1, then 0.
    reset = 1;
    tick();
    reset = 0;
    req0 = 1; req1 = 1;
    tick();
    tick();
    check("rr_a_tdata", T_data, 32'h50021111);
    wait_done(0, 300, -1, 16'h0000, cyc);
    check("rr_a_latency", 32'(cyc), 65);
    req0 = 0;
    tick();
    tick();
    check("rr_b_tdata", T_data, 32'h510E2222);
    wait_done(1, 300, -1, 16'h0000, cyc);
    check("rr_b_latency", 32'(cyc), 65);
    req1 = 0;
    tick();
    req0 = 1; req1 = 1;
    tick();
    tick();
    check("rr_c_tdata", T_data, 32'h50021111);
    wait_done(0, 300, -1, 16'h0000, cyc);
    req0 = 0;
    tick();
    tick();
    check("rr_d_tdata", T_data, 32'h510E2222);
    wait_done(1, 300, -1, 16'h0000, cyc);
    req1 = 0;
    tick();

    // Reset in the middle of WAIT aborts without a done pulse.
    req0 = 1; rd0 = 0; phy0 = 5'h1F; reg0 = 5'h12; wdata0 = 16'h28DB;
    tick();
    tick();
    for (int i = 0; i < 10; i++) tick();
    reset = 1;
    req0  = 0;
    tick();
    check_zero_outputs("midreset");
    reset = 0;
    seen  = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      seen = seen | done0 | done1 | busy | MDIO_start;
    end
    check("midreset_quiet", 32'(seen), 0);

    // Request raised while busy: sampled only once the arbiter returns to IDLE.
    req0 = 1; rd0 = 0; phy0 = 5'h1F; reg0 = 5'h12; wdata0 = 16'h28DB;
    tick();
    tick();
    check("busy_w_tdata", T_data, 32'h5FCA28DB);
    req1 = 1; rd1 = 1; phy1 = 5'h03; reg1 = 5'h04;
    for (int i = 0; i < 10; i++) tick();
    phy1 = 5'h05; reg1 = 5'h06;
    wait_done(0, 300, -1, 16'h0000, cyc);
    check("busy_w_latency", 32'(cyc), 55);
    check("busy_w_tdata_held", T_data, 32'h5FCA28DB);
    req0 = 0;
    tick();
    check("busy_r_no_start_yet", 32'(MDIO_start), 0);
    check("busy_r_busy", 32'(busy), 1);
    data_RDY = 1; RD_data = 16'h1234;
    tick();
    data_RDY = 0;
    check("busy_r_start", 32'(MDIO_start), 1);
    check("busy_r_tdata", T_data, 32'h62980000);
    wait_done(1, 300, 3, 16'hA5A5, cyc);
    check("busy_r_latency", 32'(cyc), 5);
    check("busy_r_rdata", 32'(rdata), 32'hA5A5);
    check("busy_r_err", 32'(err), 0);
    req1 = 0;
    tick();
    data_RDY = 1; RD_data = 16'h5555;
    tick();
    data_RDY = 0;
    check("idle_rdy_ignored", 32'(rdata), 32'hA5A5);
    check("idle_busy", 32'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mdio_arbiter.md
MDIO_ARBITER -- requirements
Module: mdio_arbiter

Interface
REQ-001 Parameter FRAME_CYC, default 64: clk cycles for one write frame (32 bits at mdc = clk/2).
REQ-002 Parameter TIMEOUT, default 200: clk cycles allowed for a read before abort.
REQ-003 clk  input  1  system clock, all logic on rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 req0, req1  input  1 each  transaction request; level, held until matching done.
REQ-006 rd0, rd1  input  1 each  operation select: 1 = read, 0 = write.
REQ-007 phy0, phy1  input  5 each  PHY address.
REQ-008 reg0, reg1  input  5 each  register address.
REQ-009 wdata0, wdata1  input  16 each  write data.
REQ-010 done0, done1  output  1 each  one-cycle completion pulse to the granted requester.
REQ-011 err  output  1  valid with done: 1 = read timed out.
REQ-012 rdata  output  16  read result, valid with done.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 MDIO_start  output  1  one-cycle start pulse to the MDIO transmitter.
REQ-015 T_data  output  32  frame to transmit, stable from MDIO_start until DONE.
REQ-016 data_RDY  input  1  transmitter read-data-valid pulse.
REQ-017 RD_data  input  16  transmitter read data, sampled when data_RDY = 1.

Function
REQ-018 FSM states SHALL be IDLE, START, WAIT, DONE; one transition per clk.
REQ-019 IDLE: no req -> stay; any req -> latch winner's fields, build T_data, go to START.
REQ-020 Arbitration SHALL be round-robin: single req wins; both high -> the requester not granted last wins.
REQ-021 T_data[31:0] SHALL be {ST=2'b01, OP, PHY[4:0], REG[4:0], TA, DATA[15:0]}.
REQ-022 Write fields SHALL be OP=2'b01, TA=2'b10, DATA=wdata.
REQ-023 Read fields SHALL be OP=2'b10, TA=2'b00, DATA=16'h0000.
REQ-024 START: MDIO_start=1 for exactly this cycle; clear 8-bit cycle counter; go to WAIT.
REQ-025 WAIT, write: counter increments each cycle; at counter == FRAME_CYC-1 go to DONE, err=0.
REQ-026 WAIT, read: data_RDY=1 -> register RD_data into rdata, err=0, go to DONE.
REQ-027 WAIT, read, no data_RDY by counter == TIMEOUT-1 -> rdata=16'h0000, err=1, go to DONE.
REQ-028 data_RDY during a write, or outside WAIT, SHALL be ignored.
REQ-029 DONE: pulse done0 or done1 (granted one only) for one cycle; update last-grant pointer; go to IDLE.
REQ-030 rdata and err SHALL hold their value until the next DONE.
REQ-031 Requests arriving while busy SHALL wait; fields SHALL be sampled only in IDLE.
REQ-032 Requester SHALL drop req on the edge where it samples done; req high in the following IDLE starts a new transaction.
REQ-033 Latency, req sampled in IDLE at cycle n:
  - MDIO_start at n+1
  - write done at n+2+FRAME_CYC (n+66 default)
  - read done 1 cycle after data_RDY
  - read timeout done at n+2+TIMEOUT

Reset
REQ-034 reset=1 at a clk edge SHALL force state IDLE, last-grant pointer = 1 (req0 wins first tie), counter=0.
REQ-035 Under reset, all outputs SHALL be 0: done0/1, err, rdata, busy, MDIO_start, T_data.
REQ-036 Reset mid-transaction SHALL abort with no done pulse; the transaction is not retried.

Verification
REQ-037 Write: req0=1, rd0=0, phy0=5'h1F, reg0=5'h12, wdata0=16'h28DB -> MDIO_start one cycle later; T_data=32'h5FCA28DB; done0 at +66; err=0.
REQ-038 Read: req1=1, rd1=1, phy1=5'h1F, reg1=5'h12 -> T_data=32'h6FC80000; data_RDY with RD_data=16'h0E8C -> next cycle done1=1, rdata=16'h0E8C.
REQ-039 Read timeout: req0 read, data_RDY never asserted -> done0 at +202, err=1, rdata=16'h0000.
REQ-040 Contention: req0 and req1 both high after reset -> req0 served first, then req1; both high again -> order alternates; no done while the other is in flight.
REQ-041 Reset mid-WAIT: assert reset 10 cycles after MDIO_start -> next cycle all outputs 0, no done pulse; next req proceeds normally.
REQ-042 Busy-period request: req1 raised during req0's WAIT -> req1 fields ignored until IDLE; req1's MDIO_start follows 2 cycles after done0.
